// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

endpackage

// File: rtl/ahb_sram_array.sv
// Byte-wide register-array storage: synchronous write, combinational read.
// Reads outside DEPTH return zero instead of an out-of-bounds element.
module ahb_sram_array #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 1536
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read port: combinational lookup guarded against out-of-range addresses.
    always_comb begin
        rdata = '0;
        if (32'(addr) < DEPTH) begin
            rdata = mem[addr];
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: 8-bit data, programmable wait states, two-cycle
// ERROR response above MEM_DEPTH.
// Optional macro AHB_SRAM_STATS_EN adds saturating rd_count/wr_count outputs.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned MEM_DEPTH   = 1536,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              resetn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hreadyin,
    output logic [DATA_W-1:0] hrdata,
    output logic              hreadyout,
    output logic              hresp
`ifdef AHB_SRAM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

    slave_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [3:0]        wcnt_q, wcnt_d;

    logic              accept;
    logic              in_range;
    logic              data_done;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    ahb_sram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk   (hclk),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (hwdata),
        .rdata (mem_rdata)
    );

    // State and latched address-phase registers.
    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Response outputs, accept decode and next-state selection.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        hrdata    = '0;
        data_done = 1'b0;
        state_d   = ST_IDLE;
        addr_d    = addr_q;
        write_d   = write_q;
        wcnt_d    = wcnt_q;

        unique case (state_q)
            ST_IDLE: ;
            ST_DATA: begin
                hreadyout = (wcnt_q == '0);
                data_done = (wcnt_q == '0);
                if (!write_q) begin
                    hrdata = mem_rdata;
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
            end
            ST_ERR2: begin
                hresp = HRESP_ERROR;
            end
            default: ;
        endcase

        in_range = (32'(haddr) < MEM_DEPTH);
        accept   = hreadyout && hsel && hreadyin &&
                   ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
        mem_we   = data_done && write_q;

        if (accept) begin
            addr_d  = haddr;
            write_d = hwrite;
            wcnt_d  = in_range ? WAIT_LD : '0;
            state_d = in_range ? ST_DATA : ST_ERR1;
        end else if (state_q == ST_DATA && wcnt_q != '0) begin
            wcnt_d  = wcnt_q - 4'd1;
            state_d = ST_DATA;
        end else if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end
    end

`ifdef AHB_SRAM_STATS_EN
    logic [15:0] rd_cnt_q, wr_cnt_q;

    // Saturating counts of completed OKAY transfers.
    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (data_done) begin
            if (write_q && wr_cnt_q != '1) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if (!write_q && rd_cnt_q != '1) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    // Counter outputs.
    always_comb begin
        rd_count = rd_cnt_q;
        wr_count = wr_cnt_q;
    end
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with zero wait states and
// one with three, sharing the bus signals but selected separately.
// With AHB_SRAM_STATS_EN defined, the counters of the three-wait instance are checked.
module tb_ahb_sram_slave;

    logic        hclk = 1'b0;
    logic        resetn;
    logic        hsel0, hsel3;
    logic [10:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [7:0]  hwdata;
    logic        hreadyin;
    logic [7:0]  hrdata0, hrdata3;
    logic        hreadyout0, hreadyout3;
    logic        hresp0, hresp3;
`ifdef AHB_SRAM_STATS_EN
    logic [15:0] rd_count0, wr_count0, rd_count3, wr_count3;
`endif

    int nchk = 0;
    int nerr = 0;
    int n;

    always #5 hclk = ~hclk;

    ahb_sram_slave #(
        .ADDR_W      (11),
        .DATA_W      (8),
        .MEM_DEPTH   (1536),
        .WAIT_STATES (0)
    ) u_s0 (
        .hclk      (hclk),
        .resetn    (resetn),
        .hsel      (hsel0),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hwdata    (hwdata),
        .hreadyin  (hreadyin),
        .hrdata    (hrdata0),
        .hreadyout (hreadyout0),
        .hresp     (hresp0)
`ifdef AHB_SRAM_STATS_EN
        ,
        .rd_count  (rd_count0),
        .wr_count  (wr_count0)
`endif
    );

    ahb_sram_slave #(
        .ADDR_W      (11),
        .DATA_W      (8),
        .MEM_DEPTH   (1536),
        .WAIT_STATES (3)
    ) u_s3 (
        .hclk      (hclk),
        .resetn    (resetn),
        .hsel      (hsel3),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hwdata    (hwdata),
        .hreadyin  (hreadyin),
        .hrdata    (hrdata3),
        .hreadyout (hreadyout3),
        .hresp     (hresp3)
`ifdef AHB_SRAM_STATS_EN
        ,
        .rd_count  (rd_count3),
        .wr_count  (wr_count3)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_phase(input logic s0, input logic s3, input logic [10:0] a,
                              input logic [1:0] t, input logic w);
        hsel0  = s0;
        hsel3  = s3;
        haddr  = a;
        htrans = t;
        hwrite = w;
    endtask

    task automatic idle_bus;
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    // Counts data-phase cycles with hreadyout3 low; returns at the negedge of
    // the completing cycle (or after the cycle budget expires).
    task automatic wait_rdy3(output int cnt);
        cnt = 0;
        @(negedge hclk);
        while (hreadyout3 !== 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge hclk);
        end
    endtask

    initial begin
        resetn   = 1'b0;
        hreadyin = 1'b1;
        hwdata   = 8'h00;
        haddr    = '0;
        idle_bus();
        #12;
        check("rst_ready0", 16'(hreadyout0), 16'h1);
        check("rst_resp0",  16'(hresp0),     16'h0);
        check("rst_rdata0", 16'(hrdata0),    16'h0);
        check("rst_ready3", 16'(hreadyout3), 16'h1);
`ifdef AHB_SRAM_STATS_EN
        check("rst_rdcnt", rd_count3, 16'h0);
        check("rst_wrcnt", wr_count3, 16'h0);
`endif
        tick();
        resetn = 1'b1;

        // Write A5 to 0x010, idle, then read it back (zero waits).
        addr_phase(1'b1, 1'b0, 11'h010, 2'b10, 1'b1);
        tick();
        hwdata = 8'hA5;
        idle_bus();
        @(negedge hclk);
        check("wr_ready0", 16'(hreadyout0), 16'h1);
        check("wr_rdata0", 16'(hrdata0), 16'h0);
        tick();
        addr_phase(1'b1, 1'b0, 11'h010, 2'b10, 1'b0);
        tick();
        idle_bus();
        @(negedge hclk);
        check("rd_data0",  16'(hrdata0), 16'hA5);
        check("rd_ready0", 16'(hreadyout0), 16'h1);
        check("rd_resp0",  16'(hresp0), 16'h0);
        tick();

        // Three-wait instance: write 3C to 0x020, then read it back.
        addr_phase(1'b0, 1'b1, 11'h020, 2'b10, 1'b1);
        tick();
        hwdata = 8'h3C;
        idle_bus();
        wait_rdy3(n);
        check("ws3_wr_waits", 16'(n), 16'd3);
        tick();
        addr_phase(1'b0, 1'b1, 11'h020, 2'b10, 1'b0);
        tick();
        idle_bus();
        hwdata = 8'h00;
        @(negedge hclk);
        check("ws3_rd_wait_data", 16'(hrdata3), 16'h3C);
        wait_rdy3(n);
        check("ws3_rd_waits", 16'(n + 1), 16'd3);
        check("ws3_rd_data", 16'(hrdata3), 16'h3C);
        check("ws3_rd_resp", 16'(hresp3), 16'h0);
        tick();

        // Out-of-range write to 0x700: ERR1 then ERR2, then back to OKAY.
        addr_phase(1'b1, 1'b0, 11'h700, 2'b10, 1'b1);
        tick();
        hwdata = 8'h77;
        idle_bus();
        @(negedge hclk);
        check("err1_ready", 16'(hreadyout0), 16'h0);
        check("err1_resp",  16'(hresp0), 16'h1);
        tick();
        @(negedge hclk);
        check("err2_ready", 16'(hreadyout0), 16'h1);
        check("err2_resp",  16'(hresp0), 16'h1);
        tick();
        @(negedge hclk);
        check("err_after_resp", 16'(hresp0), 16'h0);
        addr_phase(1'b1, 1'b0, 11'h010, 2'b10, 1'b0);
        tick();
        idle_bus();
        @(negedge hclk);
        check("err_then_rd", 16'(hrdata0), 16'hA5);
        check("err_then_resp", 16'(hresp0), 16'h0);
        tick();

        // Error on the three-wait instance ignores WAIT_STATES.
        addr_phase(1'b0, 1'b1, 11'h7FF, 2'b10, 1'b0);
        tick();
        idle_bus();
        @(negedge hclk);
        check("ws3_err1", {7'd0, hresp3, 7'd0, hreadyout3}, 16'h0100);
        tick();
        @(negedge hclk);
        check("ws3_err2", {7'd0, hresp3, 7'd0, hreadyout3}, 16'h0101);
        tick();

        // Last in-range byte 0x5FF; first out-of-range 0x600 pipelined into a read.
        addr_phase(1'b1, 1'b0, 11'h5FF, 2'b10, 1'b1);
        tick();
        hwdata = 8'hC3;
        addr_phase(1'b1, 1'b0, 11'h600, 2'b10, 1'b1);
        tick();
        hwdata = 8'h99;
        idle_bus();
        @(negedge hclk);
        check("edge_err1", 16'(hresp0), 16'h1);
        tick();
        addr_phase(1'b1, 1'b0, 11'h5FF, 2'b10, 1'b0);
        @(negedge hclk);
        check("edge_err2_ready", 16'(hreadyout0), 16'h1);
        tick();
        idle_bus();
        @(negedge hclk);
        check("edge_rd_data", 16'(hrdata0), 16'hC3);
        check("edge_rd_resp", 16'(hresp0), 16'h0);
        tick();

        // Back-to-back NONSEQ write then SEQ read of 0x005.
        addr_phase(1'b1, 1'b0, 11'h005, 2'b10, 1'b1);
        tick();
        hwdata = 8'h5A;
        addr_phase(1'b1, 1'b0, 11'h005, 2'b11, 1'b0);
        @(negedge hclk);
        check("b2b_wr_ready", 16'(hreadyout0), 16'h1);
        tick();
        idle_bus();
        @(negedge hclk);
        check("b2b_rd_data", 16'(hrdata0), 16'h5A);
        check("b2b_rd_ready", 16'(hreadyout0), 16'h1);
        tick();

        // Non-accepts: BUSY, hsel=0, hreadyin=0 -- none may overwrite 0x010.
        addr_phase(1'b1, 1'b0, 11'h010, 2'b01, 1'b1);
        tick();
        hwdata = 8'h00;
        idle_bus();
        @(negedge hclk);
        check("busy_ready", 16'(hreadyout0), 16'h1);
        tick();
        addr_phase(1'b0, 1'b0, 11'h010, 2'b10, 1'b1);
        tick();
        idle_bus();
        @(negedge hclk);
        check("nosel_ready", 16'(hreadyout0), 16'h1);
        tick();
        addr_phase(1'b1, 1'b0, 11'h010, 2'b10, 1'b1);
        hreadyin = 1'b0;
        tick();
        hreadyin = 1'b1;
        idle_bus();
        tick();
        addr_phase(1'b1, 1'b0, 11'h010, 2'b10, 1'b0);
        tick();
        idle_bus();
        @(negedge hclk);
        check("noacc_mem", 16'(hrdata0), 16'hA5);
        tick();

        // Reset during a three-wait write of FF to 0x030 (old value 12).
        addr_phase(1'b0, 1'b1, 11'h030, 2'b10, 1'b1);
        tick();
        hwdata = 8'h12;
        idle_bus();
        wait_rdy3(n);
        tick();
        addr_phase(1'b0, 1'b1, 11'h030, 2'b10, 1'b1);
        tick();
        hwdata = 8'hFF;
        idle_bus();
        @(negedge hclk);
        check("mid_wait_ready", 16'(hreadyout3), 16'h0);
        resetn = 1'b0;
        #1;
        check("mid_rst_ready", 16'(hreadyout3), 16'h1);
`ifdef AHB_SRAM_STATS_EN
        check("mid_rst_rdcnt", rd_count3, 16'h0);
        check("mid_rst_wrcnt", wr_count3, 16'h0);
`endif
        tick();
        tick();
        resetn = 1'b1;
        addr_phase(1'b0, 1'b1, 11'h030, 2'b10, 1'b0);
        tick();
        idle_bus();
        wait_rdy3(n);
        check("post_rst_waits", 16'(n), 16'd3);
        check("post_rst_data", 16'(hrdata3), 16'h12);
        tick();

`ifdef AHB_SRAM_STATS_EN
        // Two writes, one error (uncounted) after the read above.
        addr_phase(1'b0, 1'b1, 11'h031, 2'b10, 1'b1);
        tick();
        hwdata = 8'h01;
        idle_bus();
        wait_rdy3(n);
        tick();
        addr_phase(1'b0, 1'b1, 11'h032, 2'b10, 1'b1);
        tick();
        hwdata = 8'h02;
        idle_bus();
        wait_rdy3(n);
        tick();
        addr_phase(1'b0, 1'b1, 11'h7F0, 2'b10, 1'b1);
        tick();
        idle_bus();
        tick();
        tick();
        @(negedge hclk);
        check("stats_rd", rd_count3, 16'd1);
        check("stats_wr", wr_count3, 16'd2);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
